// File: rtl/lcd_scanout.sv
// Scans the LCD controller's column memory one page at a time after each
// rendered frame and streams it out as row-major 1-bit pixels.
module lcd_scanout #(
    parameter int WIDTH        = 96,
    parameter int PAGES        = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_ce,
    input  logic       frame_complete,
    output logic [7:0] lcd_read_x,
    output logic [3:0] lcd_read_y,
    input  logic [7:0] lcd_read_column,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       pix_data,
    output logic [6:0] pix_x,
    output logic [5:0] pix_y,
    output logic       pix_sof,
    output logic       pix_eol,
    output logic       busy,
    output logic [7:0] dropped
);

    typedef enum logic [1:0] { IDLE, FETCH, EMIT } state_e;

    localparam logic [6:0] LAST_X    = 7'(WIDTH - 1);
    localparam logic [2:0] LAST_PAGE = 3'(PAGES - 1);

    state_e     state_q;
    logic       fc_q;
    logic       pending_q;
    logic       issue_q;
    logic [7:0] dropped_q;
    logic [2:0] page_q;
    logic [2:0] row_q;
    logic [2:0] row_d;
    logic [6:0] col_q;
    logic [6:0] col_d;
    logic [6:0] x_q;
    logic [3:0] rd_y_q;
    logic       row_end;

    logic       pix_valid_q;
    logic       pix_data_q;
    logic       pix_sof_q;
    logic       pix_eol_q;
    logic [6:0] pix_x_q;
    logic [5:0] pix_y_q;

    // pipe_*_q[i] names the address presented i+1 cycles ago; the last stage
    // lines up with the column byte that address produced.
    logic       pipe_v_q [READ_LATENCY];
    logic [6:0] pipe_x_q [READ_LATENCY];
    logic [7:0] line_q   [WIDTH];

    logic       start_req;
    logic       cap_v;
    logic [6:0] cap_x;

    assign start_req = clk_ce && frame_complete && !fc_q;
    assign cap_v     = pipe_v_q[READ_LATENCY-1];
    assign cap_x     = pipe_x_q[READ_LATENCY-1];

    always_comb begin
        col_d   = col_q + 7'd1;
        row_d   = row_q;
        row_end = 1'b0;
        if (col_q == LAST_X) begin
            col_d   = '0;
            row_d   = row_q + 3'd1;
            row_end = (row_q == 3'd7);
        end
    end

    always_ff @(posedge clk) begin
        if (cap_v) begin
            line_q[cap_x] <= lcd_read_column;
        end
    end

    // Handshake: pix_valid rises only with a complete pixel; while it is high
    // every pix_* output stays frozen until an edge sees pix_ready high, and
    // the pixel transfers on exactly that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fc_q        <= 1'b0;
            pending_q   <= 1'b0;
            issue_q     <= 1'b0;
            dropped_q   <= '0;
            page_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            x_q         <= '0;
            rd_y_q      <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= 1'b0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_x_q[i] <= '0;
            end
        end else begin
            if (clk_ce) begin
                fc_q <= frame_complete;
            end

            pipe_v_q[0] <= (state_q == FETCH) && issue_q;
            pipe_x_q[0] <= x_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_x_q[i] <= pipe_x_q[i-1];
            end

            if (state_q != IDLE && start_req) begin
                if (!pending_q) begin
                    pending_q <= 1'b1;
                end else if (dropped_q != 8'hFF) begin
                    dropped_q <= dropped_q + 8'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_req || pending_q) begin
                        // A request arriving while a pending one is consumed re-arms it.
                        pending_q <= pending_q && start_req;
                        state_q   <= FETCH;
                        page_q    <= '0;
                        x_q       <= '0;
                        issue_q   <= 1'b1;
                        rd_y_q    <= '0;
                    end
                end
                FETCH: begin
                    if (issue_q) begin
                        if (x_q == LAST_X) begin
                            issue_q <= 1'b0;
                        end else begin
                            x_q <= x_q + 7'd1;
                        end
                    end
                    if (cap_v && cap_x == LAST_X) begin
                        state_q     <= EMIT;
                        col_q       <= '0;
                        row_q       <= '0;
                        pix_valid_q <= 1'b1;
                        pix_data_q  <= line_q[0][0];
                        pix_x_q     <= '0;
                        pix_y_q     <= {page_q, 3'd0};
                        pix_sof_q   <= (page_q == 3'd0);
                        pix_eol_q   <= (LAST_X == 7'd0);
                    end
                end
                EMIT: begin
                    if (pix_ready) begin
                        col_q <= col_d;
                        row_q <= row_d;
                        if (row_end) begin
                            pix_valid_q <= 1'b0;
                            pix_sof_q   <= 1'b0;
                            pix_eol_q   <= 1'b0;
                            if (page_q == LAST_PAGE) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= FETCH;
                                page_q  <= page_q + 3'd1;
                                x_q     <= '0;
                                issue_q <= 1'b1;
                                rd_y_q  <= {1'b0, page_q + 3'd1};
                            end
                        end else begin
                            pix_data_q <= line_q[col_d][row_d];
                            pix_x_q    <= col_d;
                            pix_y_q    <= {page_q, row_d};
                            pix_sof_q  <= (page_q == 3'd0) && (row_d == 3'd0) && (col_d == 7'd0);
                            pix_eol_q  <= (col_d == LAST_X);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lcd_read_x = {1'b0, x_q};
    assign lcd_read_y = rd_y_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_sof    = pix_sof_q;
    assign pix_eol    = pix_eol_q;
    assign busy       = (state_q != IDLE);
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: expected images come from a frame-level model and
// are compared by a monitor against every presented pixel.
module tb_lcd_scanout;

    localparam int W         = 96;
    localparam int FRAME_PIX = 96 * 64;
    localparam int BUDGET    = 40000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clk_ce;
    logic       fc1, fc2;
    logic       pix_ready;
    logic [7:0] rx1, rx2, col1, col2, col2_a;
    logic [3:0] ry1, ry2;
    logic       v1, d1, sof1, eol1, busy1;
    logic       v2, d2, sof2, eol2, busy2;
    logic [6:0] x1, x2;
    logic [5:0] y1, y2;
    logic [7:0] drop1, drop2;

    lcd_scanout #(.WIDTH(96), .PAGES(8), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(rst_n), .clk_ce(clk_ce), .frame_complete(fc1),
        .lcd_read_x(rx1), .lcd_read_y(ry1), .lcd_read_column(col1),
        .pix_valid(v1), .pix_ready(pix_ready), .pix_data(d1), .pix_x(x1), .pix_y(y1),
        .pix_sof(sof1), .pix_eol(eol1), .busy(busy1), .dropped(drop1)
    );

    lcd_scanout #(.WIDTH(96), .PAGES(8), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(rst_n), .clk_ce(clk_ce), .frame_complete(fc2),
        .lcd_read_x(rx2), .lcd_read_y(ry2), .lcd_read_column(col2),
        .pix_valid(v2), .pix_ready(pix_ready), .pix_data(d2), .pix_x(x2), .pix_y(y2),
        .pix_sof(sof2), .pix_eol(eol2), .busy(busy2), .dropped(drop2)
    );

    // LCD column memory: byte = x ^ (page << 4), with one or two register stages.
    function automatic logic [7:0] lcd_byte(input logic [7:0] x, input logic [3:0] p);
        return x ^ {p, 4'b0000};
    endfunction

    always @(posedge clk) col1 <= lcd_byte(rx1, ry1);
    always @(posedge clk) begin
        col2_a <= lcd_byte(rx2, ry2);
        col2   <= col2_a;
    end

    // ---------------- monitored DUT select ----------------
    logic       sel = 1'b0;
    wire        m_valid = sel ? v2    : v1;
    wire        m_data  = sel ? d2    : d1;
    wire  [6:0] m_x     = sel ? x2    : x1;
    wire  [5:0] m_y     = sel ? y2    : y1;
    wire        m_sof   = sel ? sof2  : sof1;
    wire        m_eol   = sel ? eol2  : eol1;
    wire        m_busy  = sel ? busy2 : busy1;
    wire  [7:0] m_rx    = sel ? rx2   : rx1;

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int hs_cnt      = 0;
    int sof_cnt     = 0;
    int eol_cnt     = 0;
    int idle_cnt    = 0;
    int run         = 0;
    int cyc         = 0;
    bit idle_track  = 1'b0;
    bit ce_mode     = 1'b0;
    bit rmode       = 1'b0;

    // ---------------- input driver (clk_ce, pix_ready) ----------------
    initial begin
        clk_ce    = 1'b1;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            clk_ce    = ce_mode ? (cyc % 4 == 0) : 1'b1;
            pix_ready = rmode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- reference model ----------------
    task automatic push_frame();
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < W; x++) begin
                logic [7:0] b;
                logic [6:0] px;
                logic [5:0] py;
                b  = 8'(x) ^ 8'((y / 8) << 4);
                px = 7'(x);
                py = 6'(y);
                exp_q.push_back({(x == 0 && y == 0), (x == W - 1), px, py, b[y % 8]});
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!m_busy) begin
            run = 0;
        end else if (!m_valid) begin
            run++;
        end else if (run > 0) begin
            vectors++;
            if (run != W + (sel ? 2 : 1)) begin
                miscompares++;
                $display("FAIL fetch_cycles got %0d expected %0d", run, W + (sel ? 2 : 1));
            end
            run = 0;
        end
        if (idle_track && !m_busy) idle_cnt++;
        if (m_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pixel x=%0d y=%0d with no pixel expected", m_x, m_y);
            end else begin
                if ({m_sof, m_eol, m_x, m_y, m_data} !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL pixel got sof=%b eol=%b x=%0d y=%0d d=%b expected sof=%b eol=%b x=%0d y=%0d d=%b",
                             m_sof, m_eol, m_x, m_y, m_data, exp_q[0][15], exp_q[0][14],
                             exp_q[0][13:7], exp_q[0][6:1], exp_q[0][0]);
                end
                vectors++;
                if (m_rx !== 8'd95) begin
                    miscompares++;
                    $display("FAIL lcd_read_x_in_emit got %0d expected 95", m_rx);
                end
                if (pix_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                    sof_cnt += int'(m_sof);
                    eol_cnt += int'(m_eol);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic pulse(input bit which);
        @(posedge clk);
        #2;
        if (which) fc2 = 1'b1; else fc1 = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        fc1 = 1'b0;
        fc2 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_busy) && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (exp_q.size() == 0) idle_track = 1'b0;
        end
        if (n >= BUDGET) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout remaining=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_counts();
        hs_cnt  = 0;
        sof_cnt = 0;
        eol_cnt = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        rst_n = 1'b1;
        fc1   = 1'b0;
        fc2   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", v1, 0);
        check("reset_busy", busy1, 0);
        check("reset_dropped", drop1, 0);
        check("reset_read_x", rx1, 0);
        check("reset_read_y", ry1, 0);
        check("reset_pix_x", x1, 0);
        check("reset_pix_y", y1, 0);
        check("reset_sof_eol", {sof1, eol1, d1}, 0);
        check("reset_busy2", {busy2, v2}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // single frame, always ready
        clear_counts();
        push_frame();
        pulse(1'b0);
        drain();
        check("t1_handshakes", hs_cnt, FRAME_PIX);
        check("t1_sof_count", sof_cnt, 1);
        check("t1_eol_count", eol_cnt, 64);
        check("t1_dropped", drop1, 0);

        // random backpressure
        clear_counts();
        rmode = 1'b1;
        push_frame();
        pulse(1'b0);
        drain();
        rmode = 1'b0;
        check("t2_handshakes", hs_cnt, FRAME_PIX);
        check("t2_eol_count", eol_cnt, 64);

        // two-cycle read latency instance
        clear_counts();
        sel = 1'b1;
        push_frame();
        pulse(1'b1);
        drain();
        check("t3_handshakes", hs_cnt, FRAME_PIX);
        check("t3_sof_count", sof_cnt, 1);
        @(posedge clk);
        #1 sel = 1'b0;

        // one pending request and one dropped request
        clear_counts();
        push_frame();
        push_frame();
        pulse(1'b0);
        n = 0;
        while (!busy1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_busy_after_start", busy1, 1);
        idle_cnt   = 0;
        idle_track = 1'b1;
        repeat (100) @(posedge clk);
        pulse(1'b0);
        repeat (100) @(posedge clk);
        pulse(1'b0);
        drain();
        idle_track = 1'b0;
        check("t4_dropped", drop1, 1);
        check("t4_idle_gap", idle_cnt, 1);
        check("t4_handshakes", hs_cnt, 2 * FRAME_PIX);

        // level input with a sparse clock enable yields one frame
        clear_counts();
        push_frame();
        @(posedge clk);
        #2;
        ce_mode = 1'b1;
        fc1     = 1'b1;
        repeat (50) @(posedge clk);
        #2;
        fc1     = 1'b0;
        repeat (8) @(posedge clk);
        ce_mode = 1'b0;
        drain();
        repeat (20) @(posedge clk);
        #1;
        check("t5_handshakes", hs_cnt, FRAME_PIX);
        check("t5_dropped", drop1, 1);
        check("t5_idle_after", busy1, 0);

        // reset during page 3 of EMIT
        clear_counts();
        push_frame();
        pulse(1'b0);
        n = 0;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (v1 && y1 >= 6'd24) break;
        end
        check("t6_reached_page3", (n < BUDGET), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_reset_busy", busy1, 0);
        check("t6_reset_valid", v1, 0);
        check("t6_reset_dropped", drop1, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        clear_counts();
        push_frame();
        pulse(1'b0);
        drain();
        check("t6_handshakes", hs_cnt, FRAME_PIX);
        check("t6_sof_count", sof_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Downstream consumer of the minx LCD read port.
- On each frame_complete, sweeps the LCD controller's column memory (96 columns x 8 pages, 1 byte = 8 vertical pixels) through lcd_read_x/lcd_read_y/lcd_read_column.
- Transposes each page into a row-major 1-bit pixel stream with valid/ready handshake, for the video/framebuffer writer.
- Buffers one page (96 bytes) at a time, holds one pending frame request, and counts dropped frames.

Parameters:
- WIDTH, 96, columns per page / pixels per output row.
- PAGES, 8, pages per frame; output rows = PAGES*8.
- READ_LATENCY, 1, clk cycles from lcd_read_x/y change to valid lcd_read_column (1..3).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- clk_ce, input, 1, CPU-domain clock enable; frame_complete is sampled only when high.
- frame_complete, input, 1, render-done level from minx.
- lcd_read_x, output, 8, column address to LCD controller.
- lcd_read_y, output, 4, page address to LCD controller.
- lcd_read_column, input, 8, column byte; bit i = pixel row page*8+i.
- pix_valid, output, 1, pixel available.
- pix_ready, input, 1, sink accepts pixel when pix_valid&&pix_ready.
- pix_data, output, 1, pixel value (1 = dark).
- pix_x, output, 7, pixel column 0..WIDTH-1.
- pix_y, output, 6, pixel row 0..PAGES*8-1.
- pix_sof, output, 1, high with pixel (0,0).
- pix_eol, output, 1, high with pixel x=WIDTH-1.
- busy, output, 1, high when state != IDLE.
- dropped, output, 8, saturating count of discarded frame requests.

Behaviour:
- Reset (reset low, async): state IDLE, page=0, all outputs 0, pending=0, dropped=0, frame_complete edge register=0.
- Trigger
  - On clk&&clk_ce, fc_d <= frame_complete.
  - start_req = clk_ce && frame_complete && !fc_d (one request per rising edge).
- IDLE
  - start_req -> FETCH, page=0, x=0.
  - pending set -> clear pending, then FETCH.
- FETCH
  - Drives lcd_read_y=page, lcd_read_x=x; x increments every clk (not gated by clk_ce) until WIDTH-1, then holds.
  - Byte for address x is captured into buf[x] exactly READ_LATENCY cycles after x was presented. A pipelined valid/index shift register of depth READ_LATENCY tracks this.
  - After buf[WIDTH-1] is captured -> EMIT, row=0, col=0.
  - FETCH of one page takes WIDTH+READ_LATENCY cycles.
- EMIT
  - pix_valid=1; pix_data=buf[col][row]; pix_x=col; pix_y=page*8+row.
  - pix_sof = (page==0&&row==0&&col==0); pix_eol = (col==WIDTH-1).
  - Outputs are registered and held stable while pix_valid&&!pix_ready.
  - On handshake: col++. At col=WIDTH-1: col=0, row++. At row=7 end: if page==PAGES-1 -> IDLE, else page++, FETCH.
  - No bubble between consecutive pixels of a page; pix_valid drops during each FETCH.
- lcd_read_x/lcd_read_y hold their last value outside FETCH.
- start_req while busy:
  - If !pending, set pending.
  - Else dropped++, saturating at 255.
  - The current frame is never aborted.
- start_req coinciding with the last handshake of a frame: sets pending; the next frame starts from IDLE on the following cycle.
- pix_ready held low indefinitely: block stalls, with no data loss and no further reads.
- Reset mid-frame: immediate return to IDLE; pix_valid low; partial frame abandoned.
- Widths: pix_y = {page,row[2:0]}; x comparisons are done at 7 bits.

Test Plan:
- Single frame: LCD model returns column byte = x ^ (page<<4); one frame_complete pulse with pix_ready=1 -> exactly 6144 handshakes. Pixel (x,y) = bit y[2:0] of x^(y[5:3]<<4). pix_sof only at (0,0); pix_eol 64 times.
- Backpressure: random 50% pix_ready -> identical pixel sequence to the previous test. pix_x/pix_y/pix_data stable while stalled. lcd_read_x never changes during EMIT.
- Latency: READ_LATENCY=2 with a 2-stage LCD model -> same image as the single-frame test. Each FETCH lasts 98 cycles.
- Pending/drop: three frame_complete edges during one frame -> second frame starts right after the first. dropped=1. Total handshakes 12288.
- Level input: frame_complete held high 50 cycles with clk_ce every 4th cycle -> one frame only.
- Reset mid-EMIT (page 3) -> busy=0, pix_valid=0, dropped=0 immediately. The next pulse streams from (0,0) with pix_sof=1.
